// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
//   Multi-cycle subtractor: diff = a - b, computed one 4-bit slice per clock,
//   least significant slice first. Each slice evaluates a_s + ~b_s + carry with
//   the carry held in a register between slices (initial carry = 1, so the
//   chain forms the two's-complement subtraction). Operands are accepted and
//   results delivered through valid/ready handshakes; accept and deliver never
//   overlap.
//
// Ports
//   clk         clock, all state on posedge
//   rst         asynchronous active-high reset
//   in_valid    operands valid
//   in_ready    operands accepted (high only while idle)
//   a, b        minuend / subtrahend, sampled on the input handshake
//   out_valid   result valid (high only while holding a finished result)
//   out_ready   downstream accepts the result
//   diff        a - b modulo 2^WIDTH
//   borrow_out  1 when a < b (unsigned)
//   ovf         signed overflow of a - b
//   zero        1 when diff == 0
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_borrow;
  logic             r_ovf;
  logic             r_zero;

  logic [3:0]       w_a_s;
  logic [3:0]       w_b_s;
  logic [4:0]       w_sum;
  logic [WIDTH-1:0] w_diff_nxt;
  logic             w_last;

  // Select the current slice of each operand, add, and splice the 4-bit
  // result into the partially built difference.
  always_comb begin
    w_a_s      = '0;
    w_b_s      = '0;
    w_diff_nxt = r_diff;
    for (int i = 0; i < NSLICE; i++) begin
      if (r_cnt == CW'(i)) begin
        w_a_s = r_a[4*i +: 4];
        w_b_s = r_b[4*i +: 4];
      end
    end
    w_sum = {1'b0, w_a_s} + {1'b0, ~w_b_s} + {4'b0000, r_carry};
    for (int i = 0; i < NSLICE; i++) begin
      if (r_cnt == CW'(i)) begin
        w_diff_nxt[4*i +: 4] = w_sum[3:0];
      end
    end
  end

  assign w_last = (r_cnt == CW'(NSLICE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b1;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_borrow    <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_cnt      <= '0;
            r_carry    <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_diff  <= w_diff_nxt;
          r_carry <= w_sum[4];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            // Flags use the complete difference, including the slice
            // being written on this same edge.
            r_borrow    <= ~w_sum[4];
            r_ovf       <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                           (w_diff_nxt[WIDTH-1] != r_a[WIDTH-1]);
            r_zero      <= (w_diff_nxt == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign ovf        = r_ovf;
  assign zero       = r_zero;

endmodule
